// File: rtl/rvc_pkg.sv
// Shared RV32I / RVC constants, the issue-queue entry type and RV32I
// instruction-format encoders used by the expander.
package rvc_pkg;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;

    localparam logic [1:0] QUAD0 = 2'b00;
    localparam logic [1:0] QUAD1 = 2'b01;
    localparam logic [1:0] QUAD2 = 2'b10;

    localparam logic [2:0] C0_ADDI4SPN = 3'b000;
    localparam logic [2:0] C0_LW       = 3'b010;
    localparam logic [2:0] C0_SW       = 3'b110;

    localparam logic [2:0] C1_ADDI     = 3'b000;
    localparam logic [2:0] C1_JAL      = 3'b001;
    localparam logic [2:0] C1_LI       = 3'b010;
    localparam logic [2:0] C1_LUI      = 3'b011;
    localparam logic [2:0] C1_MISC_ALU = 3'b100;
    localparam logic [2:0] C1_J        = 3'b101;
    localparam logic [2:0] C1_BEQZ     = 3'b110;
    localparam logic [2:0] C1_BNEZ     = 3'b111;

    localparam logic [2:0] C2_SLLI     = 3'b000;
    localparam logic [2:0] C2_LWSP     = 3'b010;
    localparam logic [2:0] C2_JR_MV    = 3'b100;
    localparam logic [2:0] C2_SWSP     = 3'b110;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] next_pc;
        logic        is_c;
        logic        illegal;
    } iq_entry_t;

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], STORE};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], BRANCH};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, OP};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, JAL};
    endfunction

endpackage

// File: rtl/rvc_expander.sv
// Combinational RVC -> RV32I expander. Illegal/reserved encodings
// produce illegal=1 with an all-zero instruction word.
module rvc_expander
    import rvc_pkg::*;
(
    input  logic [15:0] c,
    output logic [31:0] instr,
    output logic        illegal
);

    logic [4:0]  rd, rs2, rdp, rs1p;
    logic [11:0] imm6, imm_4spn, imm_lw, imm_16sp, imm_lwsp, imm_swsp;
    logic [19:0] imm_lui;
    logic [20:0] imm_j;
    logic [12:0] imm_b;

    assign rd   = c[11:7];
    assign rs2  = c[6:2];
    assign rdp  = {2'b01, c[4:2]};
    assign rs1p = {2'b01, c[9:7]};

    assign imm6     = {{6{c[12]}}, c[12], c[6:2]};
    assign imm_4spn = {2'b00, c[10:7], c[12:11], c[5], c[6], 2'b00};
    assign imm_lw   = {5'b0, c[5], c[12:10], c[6], 2'b00};
    assign imm_16sp = {{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0000};
    assign imm_lwsp = {4'b0, c[3:2], c[12], c[6:4], 2'b00};
    assign imm_swsp = {4'b0, c[8:7], c[12:9], 2'b00};
    assign imm_lui  = {{14{c[12]}}, c[12], c[6:2]};
    assign imm_j    = {{10{c[12]}}, c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], 1'b0};
    assign imm_b    = {{5{c[12]}}, c[6:5], c[2], c[11:10], c[4:3], 1'b0};

    // Shifts with shamt[5]=1 and the RV64-only ALU forms (bit 12 set) have no
    // RV32I equivalent, so they are flagged rather than silently truncated.
    always_comb begin
        instr   = '0;
        illegal = 1'b0;
        case (c[1:0])
            QUAD0: begin
                case (c[15:13])
                    C0_ADDI4SPN: begin
                        if (imm_4spn == '0) illegal = 1'b1;
                        else                instr = enc_i(imm_4spn, 5'd2, 3'b000, rdp, OP_IMM);
                    end
                    C0_LW:   instr = enc_i(imm_lw, rs1p, 3'b010, rdp, LOAD);
                    C0_SW:   instr = enc_s(imm_lw, rdp, rs1p, 3'b010);
                    default: illegal = 1'b1;
                endcase
            end
            QUAD1: begin
                case (c[15:13])
                    C1_ADDI: instr = enc_i(imm6, rd, 3'b000, rd, OP_IMM);
                    C1_JAL:  instr = enc_j(imm_j, 5'd1);
                    C1_LI:   instr = enc_i(imm6, 5'd0, 3'b000, rd, OP_IMM);
                    C1_LUI: begin
                        if (rd == 5'd2) begin
                            if (imm_16sp == '0) illegal = 1'b1;
                            else                instr = enc_i(imm_16sp, 5'd2, 3'b000, 5'd2, OP_IMM);
                        end else if (imm6 == '0) begin
                            illegal = 1'b1;
                        end else begin
                            instr = {imm_lui, rd, LUI};
                        end
                    end
                    C1_MISC_ALU: begin
                        case (c[11:10])
                            2'b00: begin
                                if (c[12]) illegal = 1'b1;
                                else       instr = enc_i({7'b0000000, c[6:2]}, rs1p, 3'b101, rs1p, OP_IMM);
                            end
                            2'b01: begin
                                if (c[12]) illegal = 1'b1;
                                else       instr = enc_i({7'b0100000, c[6:2]}, rs1p, 3'b101, rs1p, OP_IMM);
                            end
                            2'b10: instr = enc_i(imm6, rs1p, 3'b111, rs1p, OP_IMM);
                            default: begin
                                if (c[12]) begin
                                    illegal = 1'b1;
                                end else begin
                                    case (c[6:5])
                                        2'b00:   instr = enc_r(7'b0100000, rdp, rs1p, 3'b000, rs1p);
                                        2'b01:   instr = enc_r(7'b0000000, rdp, rs1p, 3'b100, rs1p);
                                        2'b10:   instr = enc_r(7'b0000000, rdp, rs1p, 3'b110, rs1p);
                                        default: instr = enc_r(7'b0000000, rdp, rs1p, 3'b111, rs1p);
                                    endcase
                                end
                            end
                        endcase
                    end
                    C1_J:    instr = enc_j(imm_j, 5'd0);
                    C1_BEQZ: instr = enc_b(imm_b, 5'd0, rs1p, 3'b000);
                    default: instr = enc_b(imm_b, 5'd0, rs1p, 3'b001);
                endcase
            end
            QUAD2: begin
                case (c[15:13])
                    C2_SLLI: begin
                        if (c[12]) illegal = 1'b1;
                        else       instr = enc_i({7'b0000000, c[6:2]}, rd, 3'b001, rd, OP_IMM);
                    end
                    C2_LWSP: instr = enc_i(imm_lwsp, 5'd2, 3'b010, rd, LOAD);
                    C2_JR_MV: begin
                        if (rs2 != 5'd0)     instr = enc_r(7'b0, rs2, c[12] ? rd : 5'd0, 3'b000, rd);
                        else if (rd == 5'd0) illegal = 1'b1;
                        else                 instr = enc_i(12'd0, rd, 3'b000, {4'b0, c[12]}, JALR);
                    end
                    C2_SWSP: instr = enc_s(imm_swsp, rs2, 5'd2, 3'b010);
                    default: illegal = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) instr = '0;
    end

endmodule

// File: rtl/rvc_issue_queue.sv
// Instruction issue queue: expands RVC on push, stores decoded entries in a
// circular buffer and presents the head entry straight from storage.
module rvc_issue_queue
    import rvc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [31:0]      in_instr,
    input  logic [31:0]      in_pc,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_next_pc,
    output logic             out_is_c,
    output logic             out_illegal,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    iq_entry_t        mem [DEPTH];
    iq_entry_t        new_entry;
    logic [PTR_W-1:0] head, tail;
    logic [31:0]      exp_instr;
    logic             exp_illegal;
    logic             push, pop;

    rvc_expander u_expander (
        .c       (in_instr[15:0]),
        .instr   (exp_instr),
        .illegal (exp_illegal)
    );

    always_comb begin
        new_entry.is_c    = (in_instr[1:0] != 2'b11);
        new_entry.instr   = new_entry.is_c ? exp_instr : in_instr;
        new_entry.illegal = new_entry.is_c & exp_illegal;
        new_entry.pc      = in_pc;
        new_entry.next_pc = in_pc + (new_entry.is_c ? 32'd2 : 32'd4);
    end

    assign in_ready  = (count != CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = rdy && !flush && in_valid && in_ready;
    assign pop       = rdy && !flush && out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy) begin
            if (flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) tail <= tail + PTR_W'(1);
                if (pop)  head <= head + PTR_W'(1);
                if (push && !pop)      count <= count + CNT_W'(1);
                else if (pop && !push) count <= count - CNT_W'(1);
            end
        end
    end

    // Storage is not reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push && !rst) mem[tail] <= new_entry;
    end

    assign out_instr   = mem[head].instr;
    assign out_pc      = mem[head].pc;
    assign out_next_pc = mem[head].next_pc;
    assign out_is_c    = mem[head].is_c;
    assign out_illegal = mem[head].illegal;

endmodule

// File: tb/tb_rvc_issue_queue.sv
// Self-checking bench: directed literal checks plus randomized traffic
// compared every cycle against a queue-based reference model.
module tb_rvc_issue_queue;

    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst, rdy, flush, in_valid, out_ready;
    logic [31:0]      in_instr, in_pc;
    logic             in_ready, out_valid, out_is_c, out_illegal;
    logic [31:0]      out_instr, out_pc, out_next_pc;
    logic [CNT_W-1:0] count;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] next_pc;
        bit          is_c;
        bit          ill;
    } exp_t;

    exp_t model_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 1'b0;

    rvc_issue_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .out_next_pc (out_next_pc),
        .out_is_c    (out_is_c),
        .out_illegal (out_illegal),
        .count       (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned bt(input int unsigned v, input int n);
        return (v >> n) & 1;
    endfunction

    function automatic logic [31:0] ri(input int imm, input int rs1, input int f3, input int rd, input int op);
        return 32'(((imm & 'hfff) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op);
    endfunction

    function automatic logic [31:0] rsw(input int imm, input int rs2, input int rs1);
        return 32'((((imm >> 5) & 'h7f) << 25) | (rs2 << 20) | (rs1 << 15) | (2 << 12) | ((imm & 31) << 7) | 'h23);
    endfunction

    function automatic logic [31:0] rr(input int f7, input int rs2, input int rs1, input int f3, input int rd);
        return 32'((f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h33);
    endfunction

    function automatic logic [31:0] rb(input int imm, input int rs1, input int f3);
        return 32'((((imm >> 12) & 1) << 31) | (((imm >> 5) & 63) << 25) | (rs1 << 15) | (f3 << 12) |
                   (((imm >> 1) & 15) << 8) | (((imm >> 11) & 1) << 7) | 'h63);
    endfunction

    function automatic logic [31:0] rj(input int imm, input int rd);
        return 32'((((imm >> 20) & 1) << 31) | (((imm >> 1) & 1023) << 21) | (((imm >> 11) & 1) << 20) |
                   (((imm >> 12) & 255) << 12) | (rd << 7) | 'h6f);
    endfunction

    // Reference expansion from the architectural field layouts.
    function automatic exp_t ref_entry(input logic [31:0] w, input logic [31:0] pc);
        exp_t        e;
        int unsigned c;
        int          rd, rs2, rdp, rs1p, s6, v, f3;
        e.pc = pc;
        e.is_c = (w[1:0] != 2'b11);
        e.ill = 1'b0;
        e.instr = w;
        if (e.is_c) begin
            c = {16'h0, w[15:0]};
            f3 = int'((c >> 13) & 7);
            rd = int'((c >> 7) & 31);
            rs2 = int'((c >> 2) & 31);
            rdp = 8 + int'((c >> 2) & 7);
            rs1p = 8 + int'((c >> 7) & 7);
            s6 = int'(((c >> 2) & 31) + bt(c, 12) * 32);
            if (bt(c, 12) == 1) s6 -= 64;
            e.instr = 32'h0;
            case (int'(c & 3) * 8 + f3)
                0: begin
                    v = int'(bt(c, 5) * 8 + bt(c, 6) * 4 + ((c >> 7) & 15) * 64 + ((c >> 11) & 3) * 16);
                    if (v == 0) e.ill = 1'b1;
                    else        e.instr = ri(v, 2, 0, rdp, 'h13);
                end
                2: e.instr = ri(int'(((c >> 10) & 7) * 8 + bt(c, 6) * 4 + bt(c, 5) * 64), rs1p, 2, rdp, 'h03);
                6: e.instr = rsw(int'(((c >> 10) & 7) * 8 + bt(c, 6) * 4 + bt(c, 5) * 64), rdp, rs1p);
                8: e.instr = ri(s6, rd, 0, rd, 'h13);
                9, 13: begin
                    v = int'(bt(c, 11) * 16 + ((c >> 9) & 3) * 256 + bt(c, 8) * 1024 + bt(c, 7) * 64 +
                             bt(c, 6) * 128 + ((c >> 3) & 7) * 2 + bt(c, 2) * 32) - int'(bt(c, 12)) * 2048;
                    e.instr = rj(v, (f3 == 1) ? 1 : 0);
                end
                10: e.instr = ri(s6, 0, 0, rd, 'h13);
                11: begin
                    if (rd == 2) begin
                        v = int'(bt(c, 6) * 16 + bt(c, 5) * 64 + ((c >> 3) & 3) * 128 + bt(c, 2) * 32) -
                            int'(bt(c, 12)) * 512;
                        if (v == 0) e.ill = 1'b1;
                        else        e.instr = ri(v, 2, 0, 2, 'h13);
                    end else if (s6 == 0) e.ill = 1'b1;
                    else e.instr = 32'((s6 << 12) | (rd << 7) | 'h37);
                end
                12: begin
                    case ((c >> 10) & 3)
                        0: if (bt(c, 12) == 1) e.ill = 1'b1; else e.instr = ri(rs2, rs1p, 5, rs1p, 'h13);
                        1: if (bt(c, 12) == 1) e.ill = 1'b1; else e.instr = ri('h400 + rs2, rs1p, 5, rs1p, 'h13);
                        2: e.instr = ri(s6, rs1p, 7, rs1p, 'h13);
                        default: begin
                            if (bt(c, 12) == 1) e.ill = 1'b1;
                            else case ((c >> 5) & 3)
                                0: e.instr = rr('h20, rdp, rs1p, 0, rs1p);
                                1: e.instr = rr(0, rdp, rs1p, 4, rs1p);
                                2: e.instr = rr(0, rdp, rs1p, 6, rs1p);
                                default: e.instr = rr(0, rdp, rs1p, 7, rs1p);
                            endcase
                        end
                    endcase
                end
                14, 15: begin
                    v = int'(((c >> 10) & 3) * 8 + ((c >> 5) & 3) * 64 + ((c >> 3) & 3) * 2 + bt(c, 2) * 32) -
                        int'(bt(c, 12)) * 256;
                    e.instr = rb(v, rs1p, f3 - 6);
                end
                16: if (bt(c, 12) == 1) e.ill = 1'b1; else e.instr = ri(rs2, rd, 1, rd, 'h13);
                18: e.instr = ri(int'(bt(c, 12) * 32 + ((c >> 4) & 7) * 4 + ((c >> 2) & 3) * 64), 2, 2, rd, 'h03);
                20: begin
                    if (rs2 != 0) e.instr = rr(0, rs2, (bt(c, 12) == 1) ? rd : 0, 0, rd);
                    else if (rd == 0) e.ill = 1'b1;
                    else e.instr = ri(0, rd, 0, int'(bt(c, 12)), 'h67);
                end
                22: e.instr = rsw(int'(((c >> 9) & 15) * 4 + ((c >> 7) & 3) * 64), rs2, 2);
                default: e.ill = 1'b1;
            endcase
            if (e.ill) e.instr = 32'h0;
        end
        e.next_pc = pc + (e.is_c ? 32'd2 : 32'd4);
        return e;
    endfunction

    task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                        input bit ordy, input bit fl, input bit en, input bit rs);
        exp_t e;
        bit   do_push, do_pop;
        in_valid = v; in_instr = ins; in_pc = pc;
        out_ready = ordy; flush = fl; rdy = en; rst = rs;
        e = ref_entry(ins, pc);
        do_push = v && (model_q.size() < DEPTH);
        do_pop = ordy && (model_q.size() > 0);
        @(posedge clk);
        #1;
        if (rs || (en && fl)) begin
            model_q.delete();
        end else if (en) begin
            if (do_pop) void'(model_q.pop_front());
            if (do_push) model_q.push_back(e);
        end
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("count", 32'(count), 32'(model_q.size()));
            chk("in_ready", 32'(in_ready), 32'(model_q.size() < DEPTH));
            chk("out_valid", 32'(out_valid), 32'(model_q.size() > 0));
            if (model_q.size() > 0) begin
                chk("out_instr", out_instr, model_q[0].instr);
                chk("out_pc", out_pc, model_q[0].pc);
                chk("out_next_pc", out_next_pc, model_q[0].next_pc);
                chk("out_is_c", 32'(out_is_c), 32'(model_q[0].is_c));
                chk("out_illegal", 32'(out_illegal), 32'(model_q[0].ill));
            end
        end
    end

    initial begin
        logic [31:0] w, pc;
        step(0, 0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 1, 1);
        chk_en = 1'b1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);

        step(1, 32'h0000_0405, 32'h100, 0, 0, 1, 0);
        chk("caddi_instr", out_instr, 32'h0014_0413);
        chk("caddi_is_c", 32'(out_is_c), 32'd1);
        chk("caddi_next_pc", out_next_pc, 32'h102);
        chk("caddi_illegal", 32'(out_illegal), 32'd0);
        step(1, 32'h0000_0013, 32'h200, 1, 0, 1, 0);
        chk("rv32_instr", out_instr, 32'h0000_0013);
        chk("rv32_is_c", 32'(out_is_c), 32'd0);
        chk("rv32_next_pc", out_next_pc, 32'h204);
        step(1, 32'h0000_0000, 32'h300, 1, 0, 1, 0);
        chk("zero_illegal", 32'(out_illegal), 32'd1);
        chk("zero_instr", out_instr, 32'h0);
        step(1, 32'h0000_0001, 32'hFFFF_FFFE, 1, 0, 1, 0);
        chk("wrap_next_pc", out_next_pc, 32'h0);
        step(0, 0, 0, 1, 0, 1, 0);
        chk("drained", 32'(out_valid), 32'd0);

        for (int i = 0; i < 5; i++) begin
            step(1, 32'h0000_0013, 32'(32'h1000 + 4 * i), 0, 0, 1, 0);
            if (i >= 3) begin
                chk("full_count", 32'(count), 32'd4);
                chk("full_in_ready", 32'(in_ready), 32'd0);
            end
        end
        for (int i = 0; i < 4; i++) begin
            chk("fifo_order", out_pc, 32'(32'h1000 + 4 * i));
            step(0, 0, 0, 1, 0, 1, 0);
        end
        chk("after_drain", 32'(out_valid), 32'd0);

        step(1, 32'h0000_0013, 32'h2000, 0, 0, 1, 0);
        step(1, 32'h0000_0013, 32'h2004, 0, 0, 1, 0);
        step(1, 32'h0000_0013, 32'h2008, 1, 0, 1, 0);
        chk("pushpop_count", 32'(count), 32'd2);
        chk("pushpop_head", out_pc, 32'h2004);
        step(1, 32'h0000_0013, 32'h200C, 1, 1, 1, 0);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);

        step(1, 32'h0000_0013, 32'h3000, 0, 0, 1, 0);
        step(1, 32'h0000_0013, 32'h3004, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 32'h0000_0013, 32'h3008, 1, i == 1, 0, 0);
            chk("hold_count", 32'(count), 32'd2);
            chk("hold_head", out_pc, 32'h3000);
        end

        for (int i = 0; i < 3000; i++) begin
            w = $urandom;
            if ($urandom_range(0, 9) < 7) w[1:0] = 2'($urandom_range(0, 2));
            else                          w[1:0] = 2'b11;
            pc = $urandom & 32'hFFFF_FFFE;
            if ($urandom_range(0, 15) == 0) pc = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFE : 32'hFFFF_FFFC;
            step($urandom_range(0, 9) < 6, w, pc, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 39) == 0, $urandom_range(0, 7) != 0, $urandom_range(0, 499) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rvc_issue_queue.md
RVC_ISSUE_QUEUE -- requirements
Module: rvc_issue_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; SHALL be a power of two, minimum 2.
REQ-002 Parameter CNT_W, default $clog2(DEPTH)+1, width of occupancy count.
REQ-003 clk  in  1  clock.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 rdy  in  1  global enable; low freezes all state.
REQ-006 flush  in  1  mispredict/redirect; discards all queued entries.
REQ-007 in_valid  in  1  fetcher presents an instruction.
REQ-008 in_instr  in  32  raw fetch word; bits[1:0]!=2'b11 means 16-bit RVC in bits[15:0].
REQ-009 in_pc  in  32  address of in_instr.
REQ-010 in_ready  out  1  queue accepts a push this cycle.
REQ-011 out_valid  out  1  head entry valid.
REQ-012 out_ready  in  1  issue permitted (ROB, RS and LSB all not full).
REQ-013 out_instr  out  32  head instruction, expanded to RV32I encoding.
REQ-014 out_pc  out  32  head instruction address.
REQ-015 out_next_pc  out  32  head fall-through address.
REQ-016 out_is_c  out  1  head was compressed.
REQ-017 out_illegal  out  1  head was an unsupported or reserved RVC encoding.
REQ-018 count  out  CNT_W  current occupancy, 0..DEPTH.

Function
REQ-019 Expansion SHALL be combinational at the push side; entries SHALL store the expanded word, pc, is_c, illegal and next_pc.
REQ-020 Supported RVC: C.ADDI4SPN, C.LW, C.SW, C.NOP/C.ADDI, C.JAL, C.LI, C.ADDI16SP, C.LUI, C.SRLI, C.SRAI, C.ANDI, C.SUB/XOR/OR/AND, C.J, C.BEQZ, C.BNEZ, C.SLLI, C.LWSP, C.JR, C.MV, C.JALR, C.ADD, C.SWSP; each SHALL expand to its architectural RV32I equivalent per the RVC spec (rd'/rs' = 8+field).
REQ-021 Word 0x0000, C.ADDI4SPN with nzimm=0, C.LUI/C.ADDI16SP with zero immediate, C.JR with rs1=0, and any unlisted quadrant/funct3 SHALL set illegal=1 and out_instr=32'h0.
REQ-022 32-bit words (bits[1:0]==2'b11) SHALL pass through unchanged with is_c=0.
REQ-023 next_pc = pc + (is_c ? 2 : 4), modulo 2^32.
REQ-024 Push when in_valid && in_ready; in_ready = (count != DEPTH); no same-cycle bypass when full.
REQ-025 Pop when out_valid && out_ready; out_valid = (count != 0); head outputs driven directly from storage.
REQ-026 Latency: entry pushed at edge t SHALL be visible with out_valid=1 after edge t.
REQ-027 Simultaneous push and pop: count unchanged, both pointers advance.
REQ-028 Pointers SHALL wrap modulo DEPTH.
REQ-029 flush SHALL set count, head and tail to 0 at the next edge, with priority over push and pop in the same cycle.
REQ-030 rdy=0 SHALL hold all state; flush and push/pop SHALL be ignored that cycle.
REQ-031 out_* fields SHALL be don't-care while out_valid=0.

Reset
REQ-032 rst SHALL have priority over rdy and flush.
REQ-033 On rst: count=0, head=0, tail=0, out_valid=0, in_ready=1.
REQ-034 Storage contents need not be reset.

Structure
REQ-035 Shared package rvc_pkg SHALL hold RV32I opcode constants (OP_IMM, OP, LOAD, STORE, BRANCH, JAL, JALR, LUI) and RVC quadrant/funct3 constants.
REQ-036 Sub-module rvc_expander: combinational, 16-bit in, 32-bit out plus illegal flag; instantiated once on the push path.

Verification
REQ-037 Push 0x0405 at pc 0x100 -> out_instr=0x00140413, is_c=1, next_pc=0x102, illegal=0.
REQ-038 Push 0x00000013 at pc 0x200 -> out_instr=0x00000013, is_c=0, next_pc=0x204.
REQ-039 Push 0x0000 -> out_illegal=1, out_instr=0.
REQ-040 DEPTH=4, out_ready=0, push 5 -> in_ready=0 after 4th, count=4; 5th not accepted; then drain -> FIFO order preserved.
REQ-041 count=2, push+pop in the same cycle -> count=2; flush asserted with in_valid=1 -> count=0 next cycle, out_valid=0.
REQ-042 rdy=0 for 3 cycles with in_valid=1 and out_ready=1 -> count and head unchanged.
